// File: rtl/multu_seq.sv
// Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one bit per cycle.
// Optional signed operation (extra sign port) is built when MULTU_SEQ_SIGNED_EN is defined.
module multu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               reset,
  input  logic               clock,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULTU_SEQ_SIGNED_EN
  input  logic               sign,
`endif
  input  logic               start,
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] a_load, b_load;

`ifdef MULTU_SEQ_SIGNED_EN
  logic neg_q, neg_d;
  logic a_neg, b_neg;

  // Magnitudes; the most negative value maps onto itself, read as unsigned.
  assign a_neg  = sign & a[WIDTH-1];
  assign b_neg  = sign & b[WIDTH-1];
  assign a_load = a_neg ? (~a) + WIDTH'(1) : a;
  assign b_load = b_neg ? (~b) + WIDTH'(1) : b;
`else
  assign a_load = a;
  assign b_load = b;
`endif

  // Carry out of the accumulator is kept as bit WIDTH and shifted into hi.
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ra_q} : '0);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ra_d    = ra_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef MULTU_SEQ_SIGNED_EN
    neg_d   = neg_q;
`endif
    if (start) begin
      // Start wins from either state; an operation in flight is abandoned silently.
      ra_d    = a_load;
      lo_d    = b_load;
      hi_d    = '0;
      count_d = '0;
      state_d = StRun;
`ifdef MULTU_SEQ_SIGNED_EN
      neg_d   = a_neg ^ b_neg;
`endif
    end else begin
      unique case (state_q)
        StRun: begin
          {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
          count_d      = count_q + CntW'(1);
          if (count_q == LastCount) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      ra_q    <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ra_q    <= ra_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

`ifdef MULTU_SEQ_SIGNED_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign z = neg_q ? (~{hi_q, lo_q}) + (2 * WIDTH)'(1) : {hi_q, lo_q};
`else
  assign z = {hi_q, lo_q};
`endif

  assign busy = (state_q == StRun);
  assign done = done_q;

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: scoreboard of expected products, latency and pulse checks.
module tb_multu_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic [63:0] z;
  logic        busy, done;
`ifdef MULTU_SEQ_SIGNED_EN
  logic        sign;
`endif

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  multu_seq #(.WIDTH(32)) dut (
    .reset(reset),
    .clock(clock),
    .a    (a),
    .b    (b),
`ifdef MULTU_SEQ_SIGNED_EN
    .sign (sign),
`endif
    .start(start),
    .z    (z),
    .busy (busy),
    .done (done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  function automatic logic [63:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic sv);
    logic signed [63:0] sa, sb;
    if (sv) begin
      sa = $signed({{32{av[31]}}, av});
      sb = $signed({{32{bv[31]}}, bv});
      return 64'(sa * sb);
    end
    return {32'd0, av} * {32'd0, bv};
  endfunction

  // Caller must be at a negedge; leaves the bench at the negedge right after the start edge.
  task automatic drive_start(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                             input bit abandon);
    if (abandon) exp_q.delete();
    a = av;
    b = bv;
`ifdef MULTU_SEQ_SIGNED_EN
    sign = sv;
`endif
    start = 1'b1;
    exp_q.push_back(model(av, bv, sv));
    @(negedge clock);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high (or after the cycle budget).
  task automatic wait_done(input string name);
    int  n = 0;
    bit  seen = 0;
    bit  busy_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        n = i;
        seen = 1;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1;
    end
    checks++;
    if (!seen || n != 32) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (seen=%0d), expected 32", name, n, seen);
    end
    checks++;
    if (busy_bad || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: dropped early=%0d, at done=%b, expected 0/0", name, busy_bad, busy);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: empty at done, expected one entry", name);
    end else begin
      last_exp = exp_q.pop_front();
      if (z !== last_exp) begin
        errors++;
        $display("FAIL %s result: got z=%h, expected %h", name, z, last_exp);
      end
    end
  endtask

  task automatic check_hold(input string name, input int base);
    for (int i = 0; i < 3; i++) @(negedge clock);
    checks++;
    if (z !== last_exp || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s hold: got z=%h done=%b busy=%b, expected z=%h done=0 busy=0",
               name, z, done, busy, last_exp);
    end
    checks++;
    if (done_cnt - base != 1) begin
      errors++;
      $display("FAIL %s pulses: got %0d done pulses, expected 1", name, done_cnt - base);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv);
    int base = done_cnt;
    drive_start(av, bv, sv, 1'b0);
    wait_done(name);
    check_hold(name, base);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef MULTU_SEQ_SIGNED_EN
    sign = 1'b0;
`endif
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b z=%h, expected 0 0 0", busy, done, z);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    run_op("mul_3x5", 32'd3, 32'd5, 1'b0);
    run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mul_b_zero", 32'h1234_5678, 32'd0, 1'b0);
    run_op("mul_a_zero", 32'd0, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_op("mul_rand", 32'($urandom), 32'($urandom), 1'b0);
    end
  endtask

  task automatic test_restart();
    int base = done_cnt;
    drive_start(32'd7, 32'd9, 1'b0, 1'b0);
    repeat (9) @(negedge clock);
    drive_start(32'd2, 32'h8000_0000, 1'b0, 1'b1);
    wait_done("restart");
    check_hold("restart", base);
  endtask

  task automatic test_reset_abort();
    int base = done_cnt;
    drive_start(32'd100, 32'd100, 1'b0, 1'b0);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== 64'd0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b done=%b z=%h, expected 0 0 0", busy, done, z);
    end
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    checks++;
    if (done_cnt != base || busy !== 1'b0 || z !== 64'd0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d pulses busy=%b z=%h, expected 0 pulses 0 0",
               done_cnt - base, busy, z);
    end
  endtask

  task automatic test_back_to_back();
    int base = done_cnt;
    drive_start(32'hCAFE_F00D, 32'h0000_1234, 1'b0, 1'b0);
    wait_done("b2b_first");
    drive_start(32'h0001_0001, 32'hFFFF_0000, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handoff: got done=%b busy=%b, expected 0 1", done, busy);
    end
    wait_done("b2b_second");
    check_hold("b2b_second", base + 1);
  endtask

`ifdef MULTU_SEQ_SIGNED_EN
  task automatic test_signed();
    run_op("signed_neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
    checks++;
    if (last_exp !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      errors++;
      $display("FAIL signed_model: got %h, expected FFFFFFFFFFFFFFF1", last_exp);
    end
    run_op("signed_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_op("signed_off", 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op("signed_rand", 32'($urandom), 32'($urandom), 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_reset_abort();
    test_back_to_back();
`ifdef MULTU_SEQ_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
